// File: rtl/expgob_stream_dec.sv
// Serial order-0 exp-Golomb bitstream decoder.
// One bit in per accepted beat, one 8-bit value out per codeword.
module expgob_stream_dec (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_i,
    input  logic       bit_vld_i,
    output logic       bit_rdy_o,
    output logic [7:0] dt_o,
    output logic [4:0] len_o,
    output logic       dt_vld_o,
    input  logic       dt_rdy_i,
    output logic       err_o
);

    typedef enum logic [1:0] {
        PREFIX,
        SUFFIX,
        OUT,
        ERR
    } state_t;

    state_t     state;
    logic [3:0] zcnt;
    logic [3:0] scnt;
    logic [8:0] acc;
    logic [8:0] acc_nxt;
    logic [7:0] dt_sfx;
    logic       take;

    assign take    = bit_vld_i & bit_rdy_o;
    assign acc_nxt = {acc[7:0], bit_i};
    // Low byte of acc-1 is all the output needs; acc never exceeds 256.
    assign dt_sfx  = acc_nxt[7:0] - 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PREFIX;
            zcnt      <= 4'd0;
            scnt      <= 4'd0;
            acc       <= 9'd0;
            dt_o      <= 8'd0;
            len_o     <= 5'd0;
            dt_vld_o  <= 1'b0;
            bit_rdy_o <= 1'b1;
            err_o     <= 1'b0;
        end else begin
            unique case (state)
                PREFIX: begin
                    if (take) begin
                        if (!bit_i) begin
                            if (zcnt == 4'd8) begin
                                state     <= ERR;
                                err_o     <= 1'b1;
                                bit_rdy_o <= 1'b0;
                            end else begin
                                zcnt <= zcnt + 4'd1;
                            end
                        end else begin
                            acc  <= 9'd1;
                            scnt <= zcnt;
                            if (zcnt == 4'd0) begin
                                dt_o      <= 8'd0;
                                len_o     <= 5'd1;
                                dt_vld_o  <= 1'b1;
                                bit_rdy_o <= 1'b0;
                                state     <= OUT;
                            end else begin
                                state <= SUFFIX;
                            end
                        end
                    end
                end
                SUFFIX: begin
                    if (take) begin
                        acc  <= acc_nxt;
                        scnt <= scnt - 4'd1;
                        if (scnt == 4'd1) begin
                            dt_o      <= dt_sfx;
                            len_o     <= {zcnt, 1'b1};
                            dt_vld_o  <= 1'b1;
                            bit_rdy_o <= 1'b0;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (dt_rdy_i) begin
                        dt_vld_o  <= 1'b0;
                        bit_rdy_o <= 1'b1;
                        zcnt      <= 4'd0;
                        state     <= PREFIX;
                    end
                end
                ERR: begin
                    bit_rdy_o <= 1'b0;
                    dt_vld_o  <= 1'b0;
                    err_o     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expgob_stream_dec.sv
// Self-checking bench for expgob_stream_dec: directed words plus random
// streams checked against an arithmetic exp-Golomb reference.
module tb_expgob_stream_dec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_i = 1'b0;
    logic       bit_vld_i = 1'b0;
    logic       bit_rdy_o;
    logic [7:0] dt_o;
    logic [4:0] len_o;
    logic       dt_vld_o;
    logic       dt_rdy_i = 1'b1;
    logic       err_o;

    int errors = 0;
    int checks = 0;
    bit rdy_rand = 0;

    bit stim[$];
    int exp_v[$];
    int exp_l[$];
    int got_v[$];
    int got_l[$];

    bit         hold_prev = 0;
    logic [7:0] prev_dt;
    logic [4:0] prev_len;

    expgob_stream_dec dut (
        .clk(clk),
        .rst(rst),
        .bit_i(bit_i),
        .bit_vld_i(bit_vld_i),
        .bit_rdy_o(bit_rdy_o),
        .dt_o(dt_o),
        .len_o(len_o),
        .dt_vld_o(dt_vld_o),
        .dt_rdy_i(dt_rdy_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Record output transfers and check that held data stays stable.
    always @(negedge clk) begin
        if (!rst && hold_prev && dt_vld_o) begin
            checks++;
            if (dt_o !== prev_dt || len_o !== prev_len) begin
                errors++;
                $display("FAIL hold_stable dt=%0d len=%0d want dt=%0d len=%0d",
                         dt_o, len_o, prev_dt, prev_len);
            end
        end
        if (!rst && dt_vld_o && dt_rdy_i) begin
            got_v.push_back(int'(dt_o));
            got_l.push_back(int'(len_o));
        end
        hold_prev = !rst && dt_vld_o && !dt_rdy_i;
        prev_dt   = dt_o;
        prev_len  = len_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) dt_rdy_i = 1'($urandom_range(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bit_vld_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got_v.delete();
        got_l.delete();
        exp_v.delete();
        exp_l.delete();
        stim.delete();
    endtask

    task automatic push_bit(input bit b);
        int n = 0;
        bit_i = b;
        bit_vld_i = 1'b1;
        while (!bit_rdy_o && n < 500) begin
            tick();
            n++;
        end
        if (!bit_rdy_o) begin
            checks++;
            errors++;
            $display("FAIL push_timeout bit_rdy_o=%0b want 1", bit_rdy_o);
        end
        tick();
        bit_vld_i = 1'b0;
    endtask

    task automatic send_stim(input int gap_pct);
        foreach (stim[i]) begin
            if ($urandom_range(99) < gap_pct)
                repeat ($urandom_range(4, 1)) tick();
            push_bit(stim[i]);
        end
        stim.delete();
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i] == "1");
    endtask

    // Reference encoder: N zeros then the N+1-bit binary of v+1.
    task automatic add_val(input int v);
        int m = v + 1;
        int n = 0;
        while ((m >> (n + 1)) != 0) n++;
        for (int i = 0; i < n; i++) stim.push_back(1'b0);
        for (int i = n; i >= 0; i--) stim.push_back(((m >> i) & 1) == 1);
        exp_v.push_back(v);
        exp_l.push_back(2 * n + 1);
    endtask

    task automatic wait_outputs(input int n);
        int k = 0;
        while (got_v.size() < n && k < 3000) begin
            tick();
            k++;
        end
        repeat (5) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (bit_rdy_o !== 1'b1) begin
            errors++; $display("FAIL rst_bit_rdy got=%0b want=1", bit_rdy_o);
        end
        if (dt_vld_o !== 1'b0) begin
            errors++; $display("FAIL rst_dt_vld got=%0b want=0", dt_vld_o);
        end
        if (dt_o !== 8'd0) begin
            errors++; $display("FAIL rst_dt got=%0d want=0", dt_o);
        end
        if (len_o !== 5'd0) begin
            errors++; $display("FAIL rst_len got=%0d want=0", len_o);
        end
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL rst_err got=%0b want=0", err_o);
        end
    endtask

    task automatic test_minimal();
        do_reset();
        dt_rdy_i = 1'b1;
        push_bit(1'b1);
        checks += 3;
        if (dt_vld_o !== 1'b1) begin
            errors++; $display("FAIL min_vld_rise got=%0b want=1", dt_vld_o);
        end
        if (dt_o !== 8'd0) begin
            errors++; $display("FAIL min_dt got=%0d want=0", dt_o);
        end
        if (len_o !== 5'd1) begin
            errors++; $display("FAIL min_len got=%0d want=1", len_o);
        end
        tick();
        checks += 2;
        if (dt_vld_o !== 1'b0) begin
            errors++; $display("FAIL min_vld_fall got=%0b want=0", dt_vld_o);
        end
        if (bit_rdy_o !== 1'b1) begin
            errors++; $display("FAIL min_rdy_back got=%0b want=1", bit_rdy_o);
        end
    endtask

    task automatic test_mixed();
        do_reset();
        dt_rdy_i = 1'b1;
        add_str("1");       exp_v.push_back(0);   exp_l.push_back(1);
        add_str("010");     exp_v.push_back(1);   exp_l.push_back(3);
        add_str("00110");   exp_v.push_back(5);   exp_l.push_back(5);
        add_str("0001000"); exp_v.push_back(7);   exp_l.push_back(7);
        add_str("011");     exp_v.push_back(2);   exp_l.push_back(3);
        add_str("000011111"); exp_v.push_back(30); exp_l.push_back(9);
        add_str("00000000100000000");
        exp_v.push_back(255); exp_l.push_back(17);
        send_stim(0);
        wait_outputs(exp_v.size());
        checks++;
        if (got_v.size() !== exp_v.size()) begin
            errors++;
            $display("FAIL mixed_count got=%0d want=%0d", got_v.size(), exp_v.size());
        end
        foreach (exp_v[i]) begin
            if (i < got_v.size()) begin
                checks++;
                if (got_v[i] !== exp_v[i] || got_l[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL mixed_word%0d got=%0d/%0d want=%0d/%0d",
                             i, got_v[i], got_l[i], exp_v[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        dt_rdy_i = 1'b0;
        add_str("00110");
        send_stim(30);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (dt_vld_o !== 1'b1 || bit_rdy_o !== 1'b0 || dt_o !== 8'd5) begin
                errors++;
                $display("FAIL bp_hold%0d vld=%0b rdy=%0b dt=%0d want 1/0/5",
                         c, dt_vld_o, bit_rdy_o, dt_o);
            end
            tick();
        end
        dt_rdy_i = 1'b1;
        add_str("010");
        send_stim(30);
        wait_outputs(2);
        checks++;
        if (got_v.size() !== 2 || got_v[0] !== 5 || got_v[1] !== 1) begin
            errors++;
            $display("FAIL bp_resume count=%0d first=%0d want 2 words 5,1",
                     got_v.size(), got_v.size() > 0 ? got_v[0] : -1);
        end
    endtask

    task automatic test_random(input int gap_pct, input bit rr, input string tag);
        do_reset();
        dt_rdy_i = 1'b1;
        rdy_rand = rr;
        for (int i = 0; i < 40; i++) add_val(int'($urandom_range(255)));
        add_val(255);
        add_val(0);
        send_stim(gap_pct);
        wait_outputs(exp_v.size());
        rdy_rand = 0;
        dt_rdy_i = 1'b1;
        checks++;
        if (got_v.size() !== exp_v.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d want=%0d", tag, got_v.size(), exp_v.size());
        end
        foreach (exp_v[i]) begin
            if (i < got_v.size()) begin
                checks++;
                if (got_v[i] !== exp_v[i] || got_l[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL %s_word%0d got=%0d/%0d want=%0d/%0d",
                             tag, i, got_v[i], got_l[i], exp_v[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_error();
        do_reset();
        dt_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) push_bit(1'b0);
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL err_early got=%0b want=0", err_o);
        end
        push_bit(1'b0);
        checks++;
        if (err_o !== 1'b1 || bit_rdy_o !== 1'b0 || dt_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL err_enter err=%0b rdy=%0b vld=%0b want 1/0/0",
                     err_o, bit_rdy_o, dt_vld_o);
        end
        bit_i = 1'b1;
        bit_vld_i = 1'b1;
        repeat (6) tick();
        bit_vld_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || bit_rdy_o !== 1'b0 || dt_vld_o !== 1'b0
            || got_v.size() !== 0) begin
            errors++;
            $display("FAIL err_sticky err=%0b rdy=%0b vld=%0b outs=%0d want 1/0/0/0",
                     err_o, bit_rdy_o, dt_vld_o, got_v.size());
        end
        do_reset();
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL err_clear got=%0b want=0", err_o);
        end
        push_bit(1'b1);
        wait_outputs(1);
        checks++;
        if (got_v.size() !== 1 || got_v[0] !== 0 || got_l[0] !== 1) begin
            errors++;
            $display("FAIL err_recover count=%0d want one word 0/1", got_v.size());
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        dt_rdy_i = 1'b1;
        add_str("00010");
        send_stim(0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        add_str("010");
        send_stim(0);
        wait_outputs(1);
        repeat (20) tick();
        checks++;
        if (got_v.size() !== 1 || got_v[0] !== 1 || got_l[0] !== 3) begin
            errors++;
            $display("FAIL mid_rst count=%0d first=%0d want one word 1/3",
                     got_v.size(), got_v.size() > 0 ? got_v[0] : -1);
        end
    endtask

    task automatic test_reset_out();
        do_reset();
        dt_rdy_i = 1'b0;
        add_str("00110");
        send_stim(0);
        checks++;
        if (dt_vld_o !== 1'b1 || dt_o !== 8'd5) begin
            errors++;
            $display("FAIL out_rst_pre vld=%0b dt=%0d want 1/5", dt_vld_o, dt_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dt_vld_o !== 1'b0 || bit_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL out_rst_drop vld=%0b rdy=%0b want 0/1", dt_vld_o, bit_rdy_o);
        end
        dt_rdy_i = 1'b1;
        repeat (10) tick();
        checks++;
        if (got_v.size() !== 0) begin
            errors++;
            $display("FAIL out_rst_leak transfers=%0d want=0", got_v.size());
        end
    endtask

    initial begin
        test_reset();
        test_minimal();
        test_mixed();
        test_backpressure();
        test_random(0, 0, "b2b");
        test_random(35, 1, "rand");
        test_error();
        test_reset_mid_word();
        test_reset_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
